serial_word_assembler: RTL and testbench
========================================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, assembled word width (2..64).
REQ-002 SHALL have parameter: MSB_FIRST, default 1; 1 = first accepted bit lands in word_o[WIDTH-1], 0 = first bit lands in word_o[0].
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: bit_i  input  1  serial data bit.
REQ-006 SHALL have port: bit_valid_i  input  1  bit_i is valid this cycle.
REQ-007 SHALL have port: bit_ready_o  output  1  block accepts a bit this cycle.
REQ-008 SHALL have port: flush_i  input  1  synchronous discard of a partial word.
REQ-009 SHALL have port: word_o  output  WIDTH  assembled word; feeds the downstream bus pass-through stage.
REQ-010 SHALL have port: word_valid_o  output  1  word_o holds a complete word.
REQ-011 SHALL have port: word_ready_i  input  1  downstream accepts word_o.
REQ-012 SHALL have port: parity_err_o  output  1  parity mismatch, qualified by word_valid_o.

Function
REQ-013 SHALL implement FSM states FILL and HOLD; bit_ready_o = (state==FILL).
REQ-014 SHALL accept a bit when bit_valid_i && bit_ready_o; accepted bit is shifted into the shift register at the MSB_FIRST-selected end and the bit counter is incremented.
REQ-015 SHALL go FILL->HOLD on the cycle the last bit of a word is accepted (bit WIDTH without parity; the parity bit with parity); word_valid_o=1 from the next cycle.
REQ-016 SHALL hold word_o, word_valid_o and parity_err_o stable in HOLD until word_ready_i=1; on that handshake, go HOLD->FILL and clear counter and word_valid_o on the next cycle.
REQ-017 SHALL not accept bits in HOLD (no bypass); one idle input cycle per word is permitted.
REQ-018 SHALL, on flush_i=1 in FILL, clear counter and shift register; a bit handshaken in the same cycle is discarded (flush wins).
REQ-019 SHALL ignore flush_i in HOLD.
REQ-020 SHALL wrap counter to 0 on every word completion; counter width is clog2(WIDTH+1).
REQ-021 SHALL drive word_o only from the registered shift register (no combinational path from bit_i).

Reset
REQ-022 SHALL, on rst=1 at any time including mid-word, immediately force state=FILL, counter=0, word_o=0, word_valid_o=0, parity_err_o=0; any partial word is lost.
REQ-023 SHALL make bit_ready_o=1 in the first cycle after rst is released.

Configuration
REQ-024 SHALL support macro SERIAL_WORD_ASSEMBLER_PARITY_EN.
REQ-025 With the macro defined: one extra bit (even parity over the WIDTH data bits) is consumed after the data bits; parity_err_o=1 if the total number of ones (data + parity) is odd; the parity bit is not stored in word_o.
REQ-026 Without the macro: exactly WIDTH bits form a word; the parity_err_o port exists and is tied to 0.

Structure
REQ-027 SHALL place the FSM state enum (FILL, HOLD) and a default-width constant (32) in package serial_word_assembler_pkg.
REQ-028 SHALL instantiate one sub-module, swa_shift_reg (shift register plus bit counter, parameterised by WIDTH and MSB_FIRST); FSM, flush and parity logic stay in the top.

Verification
REQ-029 SHALL cover: MSB_FIRST=1, bits of 0xDEADBEEF sent back-to-back, word_ready_i=1 -> word_o=0xDEADBEEF, word_valid_o high exactly 1 cycle, asserted the cycle after the 32nd bit.
REQ-030 SHALL cover: MSB_FIRST=0, bits 1,0,0,...,0 -> word_o=0x00000001.
REQ-031 SHALL cover: word_ready_i=0 for 5 cycles after word_valid_o -> word_o stable, bit_ready_o=0 throughout; the next word is accepted only after the handshake.
REQ-032 SHALL cover: 10 bits, then flush_i with bit_valid_i=1, then 32 bits of 0x00000001 -> word_o=0x00000001; the flushed and coincident bits are absent from it.
REQ-033 SHALL cover: rst asserted after 17 bits -> all outputs 0 at once; the next 32 bits of 0xA5A5A5A5 -> word_o=0xA5A5A5A5.
REQ-034 SHALL cover, with SERIAL_WORD_ASSEMBLER_PARITY_EN: data 0x00000003 with parity bit 1 -> parity_err_o=1; the same data with parity bit 0 -> parity_err_o=0.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
// +------------------------------------------------------------------+
// | serial_word_assembler_pkg : shared FSM state type and defaults   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package serial_word_assembler_pkg;

  localparam int unsigned SWA_DEFAULT_WIDTH = 32;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } swa_state_e;

endpackage

`default_nettype wire

// File: rtl/swa_shift_reg.sv
// +------------------------------------------------------------------+
// | swa_shift_reg : serial-in shift register with accepted-bit count |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module swa_shift_reg
  import serial_word_assembler_pkg::*;
#(
  parameter int unsigned WIDTH     = SWA_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         shift_i,
  input  logic                         inc_i,
  input  logic                         wrap_i,
  input  logic                         bit_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int unsigned c_cnt_w = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   data_q, data_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [WIDTH-1:0]   w_shifted;

  // The end bits enter from decides where the first bit finally lands.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {data_q[WIDTH-2:0], bit_i};
    end else begin : g_lsb_first
      assign w_shifted = {bit_i, data_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clr_i) begin
      data_d  = '0;
      count_d = '0;
    end else begin
      if (shift_i) data_d = w_shifted;
      if (wrap_i) begin
        count_d = '0;
      end else if (inc_i) begin
        count_d = count_q + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_assembler.sv
// +------------------------------------------------------------------+
// | serial_word_assembler : bit stream to word, valid/ready output.  |
// | Optional parity bit: define SERIAL_WORD_ASSEMBLER_PARITY_EN.     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int unsigned WIDTH     = SWA_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic             bit_ready_o,
  input  logic             flush_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             parity_err_o
);

  localparam int unsigned c_cnt_w = $clog2(WIDTH + 1);

  swa_state_e         state_q, state_d;
  logic [c_cnt_w-1:0] w_count;
  logic               w_last;
  logic               w_data_bit;
  logic               w_flush;
  logic               w_shift;
  logic               w_inc;
  logic               w_wrap;

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  // The parity bit follows the data bits and never enters the shift register.
  assign w_last     = (w_count == c_cnt_w'(WIDTH));
  assign w_data_bit = !w_last;
`else
  assign w_last     = (w_count == c_cnt_w'(WIDTH - 1));
  assign w_data_bit = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    w_flush = 1'b0;
    w_shift = 1'b0;
    w_inc   = 1'b0;
    w_wrap  = 1'b0;
    case (state_q)
      FILL: begin
        if (flush_i) begin
          w_flush = 1'b1;
        end else if (bit_valid_i) begin
          w_inc   = 1'b1;
          w_shift = w_data_bit;
          if (w_last) begin
            w_wrap  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (word_ready_i) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  swa_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (w_flush),
    .shift_i (w_shift),
    .inc_i   (w_inc),
    .wrap_i  (w_wrap),
    .bit_i   (bit_i),
    .data_o  (word_o),
    .count_o (w_count)
  );

  assign bit_ready_o  = (state_q == FILL);
  assign word_valid_o = (state_q == HOLD);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  logic par_acc_q, par_acc_d;
  logic par_err_q, par_err_d;

  // Running XOR of the word so far; the error flag is the XOR including parity.
  always_comb begin
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
    if (w_flush) begin
      par_acc_d = 1'b0;
    end else if (w_inc) begin
      if (w_last) begin
        par_err_d = par_acc_q ^ bit_i;
        par_acc_d = 1'b0;
      end else begin
        par_acc_d = par_acc_q ^ bit_i;
      end
    end
    if ((state_q == HOLD) && word_ready_i) par_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
    end
  end

  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_word_assembler.sv
// +------------------------------------------------------------------+
// | tb_serial_word_assembler : scoreboard bench, MSB- and LSB-first. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module tb_serial_word_assembler;

  localparam int W = 32;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_i = 1'b0;
  logic         bit_valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         word_ready_i = 1'b0;
  logic         rdy_m, rdy_l, val_m, val_l, perr_m, perr_l;
  logic [W-1:0] word_m, word_l;

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .bit_ready_o(rdy_m), .flush_i(flush_i), .word_o(word_m),
    .word_valid_o(val_m), .word_ready_i(word_ready_i), .parity_err_o(perr_m)
  );

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .bit_ready_o(rdy_l), .flush_i(flush_i), .word_o(word_l),
    .word_valid_o(val_l), .word_ready_i(word_ready_i), .parity_err_o(perr_l)
  );

  typedef struct {
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    logic         perr;
  } exp_t;

  exp_t         sb[$];
  bit           m_bits[$];
  bit           m_hold = 1'b0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] last_m = '0;
  logic [W-1:0] last_l = '0;
  logic         last_perr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word built straight from the list of accepted bits.
  function automatic exp_t make_exp();
    exp_t e;
    e.wm   = '0;
    e.wl   = '0;
    e.perr = 1'b0;
    for (int i = 0; i < W; i++) begin
      e.wm[W-1-i] = m_bits[i];
      e.wl[i]     = m_bits[i];
    end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    for (int i = 0; i < NB; i++) e.perr = e.perr ^ m_bits[i];
`endif
    return e;
  endfunction

  // Reference model: collect accepted bits, emit a word after NB of them.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_hold = 1'b0;
        m_bits.delete();
        sb.delete();
      end else if (m_hold) begin
        if (word_ready_i) m_hold = 1'b0;
      end else if (flush_i) begin
        m_bits.delete();
      end else if (bit_valid_i) begin
        m_bits.push_back(bit_i);
        if (m_bits.size() == NB) begin
          sb.push_back(make_exp());
          m_bits.delete();
          m_hold = 1'b1;
        end
      end
    end
  end

  // Monitor: per-cycle handshake checks, scoreboard pop on word handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("bit_ready_m", 64'(rdy_m), 64'(!m_hold));
        chk("bit_ready_l", 64'(rdy_l), 64'(!m_hold));
        chk("word_valid_m", 64'(val_m), 64'(m_hold));
        chk("word_valid_l", 64'(val_l), 64'(m_hold));
        if (val_m && word_ready_i) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got unexpected word %0h expected none", word_m);
          end else begin
            e = sb.pop_front();
            chk("word_m", 64'(word_m), 64'(e.wm));
            chk("word_l", 64'(word_l), 64'(e.wl));
            chk("parity_err_m", 64'(perr_m), 64'(e.perr));
            chk("parity_err_l", 64'(perr_l), 64'(e.perr));
            last_m    = word_m;
            last_l    = word_l;
            last_perr = perr_m;
          end
        end
      end
    end
  end

  task automatic cyc(input logic b, input logic v, input logic f, input logic r);
    @(posedge clk);
    #2;
    bit_i        = b;
    bit_valid_i  = v;
    flush_i      = f;
    word_ready_i = r;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic par, input logic r);
    for (int i = 0; i < W; i++) cyc(d[W-1-i], 1'b1, 1'b0, r);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    cyc(par, 1'b1, 1'b0, r);
`else
    if (par) cyc(1'b0, 1'b0, 1'b0, r);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic even_par(input logic [W-1:0] d);
    return ^d;
  endfunction

  initial begin
    logic [W-1:0] d;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_word_m", 64'(word_m), 64'd0);
    chk("reset_valid_m", 64'(val_m), 64'd0);
    chk("reset_perr_m", 64'(perr_m), 64'd0);
    rst = 1'b0;

    // Back-to-back word with the downstream always ready.
    d = 32'hDEADBEEF;
    send_word(d, even_par(d), 1'b1);
    idle(2);
    chk("deadbeef", 64'(last_m), 64'hDEADBEEF);

    // First bit 1 then zeros: LSB-first instance yields 1.
    d = 32'h80000000;
    send_word(d, even_par(d), 1'b1);
    idle(2);
    chk("lsb_first_one", 64'(last_l), 64'h1);

    // Downstream stalls for five cycles while bits keep arriving.
    d = 32'h12345678;
    send_word(d, even_par(d), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'($urandom), 1'b1, 1'b0, 1'b0);
    idle(1);
    d = 32'hCAFEF00D;
    send_word(d, even_par(d), 1'b1);
    idle(2);
    chk("after_stall", 64'(last_m), 64'hCAFEF00D);

    // Flush after ten bits, with a coincident valid bit.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    d = 32'h00000001;
    send_word(d, even_par(d), 1'b1);
    idle(2);
    chk("after_flush", 64'(last_m), 64'h1);

    // Reset mid-word after 17 bits.
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bit_valid_i = 1'b0;
    #1;
    chk("rst_word_m", 64'(word_m), 64'd0);
    chk("rst_word_l", 64'(word_l), 64'd0);
    chk("rst_valid_m", 64'(val_m), 64'd0);
    chk("rst_valid_l", 64'(val_l), 64'd0);
    chk("rst_perr_m", 64'(perr_m), 64'd0);
    chk("rst_perr_l", 64'(perr_l), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    d = 32'hA5A5A5A5;
    send_word(d, even_par(d), 1'b1);
    idle(2);
    chk("after_reset", 64'(last_m), 64'hA5A5A5A5);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    send_word(32'h00000003, 1'b1, 1'b1);
    idle(2);
    chk("parity_bad", 64'(last_perr), 64'd1);
    send_word(32'h00000003, 1'b0, 1'b1);
    idle(2);
    chk("parity_good", 64'(last_perr), 64'd0);
`endif

    // Randomised traffic: gaps, rare flushes, downstream back-pressure.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0),
          ($urandom_range(0, 2) != 0));
    end
    idle(4);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
